tx_intlvr_sched: RTL and testbench

TX_INTLVR_SCHED -- requirements
Module: tx_intlvr_sched

---
 rtl/tx_intlvr_sched_pkg.sv | 36 +++
 rtl/tx_intlvr_sched_if.sv | 19 +
 rtl/tx_intlvr_mod_lut.sv | 40 ++++
 rtl/tx_intlvr_sched.sv | 147 ++++++++++++++
 tb/tb_tx_intlvr_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_intlvr_sched_pkg.sv
// Shared encodings for the TX interleaver scheduler: modulation codes,
// per-modulation symbol sizes and pattern-ROM windows, and FSM states.
package tx_intlvr_sched_pkg;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_16QAM = 2'd2,
    MOD_64QAM = 2'd3
  } mod_e;

  localparam logic [8:0] NCBPS_BPSK  = 9'd48;
  localparam logic [8:0] NCBPS_QPSK  = 9'd96;
  localparam logic [8:0] NCBPS_16QAM = 9'd192;
  localparam logic [8:0] NCBPS_64QAM = 9'd288;

  // The four windows tile the pattern ROM back to back.
  localparam logic [9:0] ROM_START_BPSK  = 10'd0;
  localparam logic [9:0] ROM_END_BPSK    = 10'd47;
  localparam logic [9:0] ROM_START_QPSK  = 10'd48;
  localparam logic [9:0] ROM_END_QPSK    = 10'd143;
  localparam logic [9:0] ROM_START_16QAM = 10'd144;
  localparam logic [9:0] ROM_END_16QAM   = 10'd335;
  localparam logic [9:0] ROM_START_64QAM = 10'd336;
  localparam logic [9:0] ROM_END_64QAM   = 10'd623;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_PAD      = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/tx_intlvr_sched_if.sv
// Bit-stream handshake between puncturer, scheduler and interleaver.
interface tx_intlvr_sched_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic intlvr_in_valid;
  logic intlvr_in_bit;
  logic intlvr_out_valid;

  // master: the scheduler; slave: the puncturer/interleaver environment.
  modport master (
    input  in_valid, in_bit, intlvr_out_valid,
    output in_ready, intlvr_in_valid, intlvr_in_bit
  );
  modport slave (
    output in_valid, in_bit, intlvr_out_valid,
    input  in_ready, intlvr_in_valid, intlvr_in_bit
  );
endinterface

// File: rtl/tx_intlvr_mod_lut.sv
// Combinational lookup: modulation -> coded bits per symbol and ROM window.
module tx_intlvr_mod_lut
  import tx_intlvr_sched_pkg::*;
(
  input  mod_e       mod_i,
  output logic [8:0] ncbps_o,
  output logic [9:0] rom_start_o,
  output logic [9:0] rom_end_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ncbps_o     = NCBPS_BPSK;
    rom_start_o = ROM_START_BPSK;
    rom_end_o   = ROM_END_BPSK;
    unique case (mod_i)
      MOD_BPSK: begin
        ncbps_o     = NCBPS_BPSK;
        rom_start_o = ROM_START_BPSK;
        rom_end_o   = ROM_END_BPSK;
      end
      MOD_QPSK: begin
        ncbps_o     = NCBPS_QPSK;
        rom_start_o = ROM_START_QPSK;
        rom_end_o   = ROM_END_QPSK;
      end
      MOD_16QAM: begin
        ncbps_o     = NCBPS_16QAM;
        rom_start_o = ROM_START_16QAM;
        rom_end_o   = ROM_END_16QAM;
      end
      MOD_64QAM: begin
        ncbps_o     = NCBPS_64QAM;
        rom_start_o = ROM_START_64QAM;
        rom_end_o   = ROM_END_64QAM;
      end
    endcase
  end

endmodule

// File: rtl/tx_intlvr_sched.sv
// Frame scheduler: cuts the coded-bit stream into per-symbol interleaver bursts,
// zero-pads the last symbol, and paces bursts on interleaver output activity.
module tx_intlvr_sched
  import tx_intlvr_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 2,   // must be >= 1
  parameter int unsigned WAIT_TIMEOUT = 1023 // must be >= 1
) (
  input  logic              clk_Modulation,
  input  logic              reset,
  input  logic [1:0]        tx_Modulation,
  input  logic              frame_start,
  input  logic [15:0]       frame_bit_len,
  tx_intlvr_sched_if.master bus,
  output logic [9:0]        rom_start_addr,
  output logic [9:0]        rom_end_addr,
  output logic [8:0]        ncbps,
  output logic [9:0]        sym_cnt,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int GAP_W  = $clog2(GAP_CYCLES + 2);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 2);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

  state_e            state_q;
  mod_e              mod_q;
  logic [15:0]       len_q;
  logic [15:0]       frame_bit_q;
  logic [8:0]        sym_bit_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              out_seen_q;
  logic [9:0]        sym_cnt_q;
  logic              err_q;
  logic              ivalid_q;
  logic              ibit_q;

  logic beat;
  logic sym_last;
  logic frame_last;

  tx_intlvr_mod_lut u_mod_lut (
    .mod_i       (mod_q),
    .ncbps_o     (ncbps),
    .rom_start_o (rom_start_addr),
    .rom_end_o   (rom_end_addr)
  );

  assign beat       = (state_q == ST_LOAD) && bus.in_valid;
  assign sym_last   = (sym_bit_q == ncbps - 9'd1);
  assign frame_last = (frame_bit_q + 16'd1 == len_q);

  always_ff @(posedge clk_Modulation) begin
    // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      mod_q       <= MOD_BPSK;
      len_q       <= '0;
      frame_bit_q <= '0;
      sym_bit_q   <= '0;
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      out_seen_q  <= 1'b0;
      sym_cnt_q   <= '0;
      err_q       <= 1'b0;
      ivalid_q    <= 1'b0;
      ibit_q      <= 1'b0;
    end else begin
      ivalid_q <= 1'b0;
      ibit_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            mod_q       <= mod_e'(tx_Modulation);
            len_q       <= frame_bit_len;
            frame_bit_q <= '0;
            sym_bit_q   <= '0;
            sym_cnt_q   <= '0;
            state_q     <= (frame_bit_len != 16'd0) ? ST_LOAD : ST_DONE;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            ivalid_q    <= 1'b1;
            ibit_q      <= bus.in_bit;
            frame_bit_q <= frame_bit_q + 16'd1;
            // A full symbol closes the burst even if the frame ends on the same bit.
            if (sym_last) begin
              sym_bit_q <= '0;
              state_q   <= ST_GAP;
            end else begin
              sym_bit_q <= sym_bit_q + 9'd1;
              if (frame_last) state_q <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          ivalid_q <= 1'b1;
          if (sym_last) begin
            sym_bit_q <= '0;
            state_q   <= ST_GAP;
          end else begin
            sym_bit_q <= sym_bit_q + 9'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q  <= '0;
            wait_cnt_q <= '0;
            out_seen_q <= 1'b0;
            state_q    <= ST_WAIT_OUT;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_WAIT_OUT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          // Falling edge of interleaver output marks the symbol as consumed.
          if (out_seen_q && !bus.intlvr_out_valid) begin
            if (sym_cnt_q != 10'h3FF) sym_cnt_q <= sym_cnt_q + 10'd1;
            state_q <= (frame_bit_q != len_q) ? ST_LOAD : ST_DONE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (bus.intlvr_out_valid) begin
            out_seen_q <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready        = (state_q == ST_LOAD);
  assign bus.intlvr_in_valid = ivalid_q;
  assign bus.intlvr_in_bit   = ibit_q;
  assign sym_cnt             = sym_cnt_q;
  assign busy                = (state_q != ST_IDLE);
  assign frame_done          = (state_q == ST_DONE);
  assign err                 = err_q;

endmodule

// File: tb/tb_tx_intlvr_sched.sv
// Self-checking bench: random data frames compared against a symbol-level model
// (ceil(len/ncbps) bursts, data then zero fill), plus timeout and reset cases.
module tb_tx_intlvr_sched;

  localparam int GAP_CYCLES   = 2;
  localparam int WAIT_TIMEOUT = 1023;

  logic        clk;
  logic        reset;
  logic [1:0]  tx_mod;
  logic        frame_start;
  logic [15:0] frame_bit_len;
  logic [9:0]  rom_start_addr;
  logic [9:0]  rom_end_addr;
  logic [8:0]  ncbps;
  logic [9:0]  sym_cnt;
  logic        busy;
  logic        frame_done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  bit err_exp  = 1'b0;

  tx_intlvr_sched_if bus ();

  tx_intlvr_sched #(
    .GAP_CYCLES   (GAP_CYCLES),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) dut (
    .clk_Modulation (clk),
    .reset          (reset),
    .tx_Modulation  (tx_mod),
    .frame_start    (frame_start),
    .frame_bit_len  (frame_bit_len),
    .bus            (bus),
    .rom_start_addr (rom_start_addr),
    .rom_end_addr   (rom_end_addr),
    .ncbps          (ncbps),
    .sym_cnt        (sym_cnt),
    .busy           (busy),
    .frame_done     (frame_done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Symbol size is 48 bits times the bits-per-subcarrier factor.
  function automatic int mod_ncbps(input int m);
    int mult[4];
    mult = '{1, 2, 4, 6};
    return 48 * mult[m];
  endfunction

  // ROM windows are laid out consecutively in modulation order.
  function automatic int mod_rom_start(input int m);
    int s = 0;
    for (int k = 0; k < m; k++) s += mod_ncbps(k);
    return s;
  endfunction

  task automatic check_window(input string tag, input int m);
    check({tag, "_ncbps"},    32'(ncbps),          32'(mod_ncbps(m)));
    check({tag, "_rom_start"}, 32'(rom_start_addr), 32'(mod_rom_start(m)));
    check({tag, "_rom_end"},  32'(rom_end_addr),   32'(mod_rom_start(m) + mod_ncbps(m) - 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(busy),                32'(0));
    check({tag, "_done"},   32'(frame_done),          32'(0));
    check({tag, "_err"},    32'(err),                 32'(0));
    check({tag, "_ready"},  32'(bus.in_ready),        32'(0));
    check({tag, "_ivalid"}, 32'(bus.intlvr_in_valid), 32'(0));
    check({tag, "_ibit"},   32'(bus.intlvr_in_bit),   32'(0));
    check({tag, "_symcnt"}, 32'(sym_cnt),             32'(0));
    check_window(tag, 0);
  endtask

  // vmode: 0 continuous, 1 every other cycle, 2 random.
  // ilv_en=0 models a silent interleaver; abort_at>=0 asserts reset at that cycle.
  task automatic run_frame(input int mod, input int len, input int vmode, input bit ilv_en,
                           input int inject_at, input int abort_at);
    bit   data[$];
    bit   out_q[$];
    int   nb = mod_ncbps(mod);
    int   nsym;
    int   idx = 0;
    int   ilv_cnt = 0, ilv_phase = 0, ilv_timer = 0;
    int   n_bursts = 0, min_gap = 1 << 30, idle_run = 0;
    int   last_vc = -1, done_c = -1, first_bad = -1;
    bit   vld, exp_bit;
    for (int i = 0; i < len; i++) data.push_back(1'($urandom));
    nsym = (len + nb - 1) / nb;

    @(negedge clk);
    frame_start   = 1'b1;
    tx_mod        = 2'(mod);
    frame_bit_len = 16'(len);
    @(negedge clk);
    frame_start   = 1'b0;
    tx_mod        = 2'($urandom);
    frame_bit_len = 16'($urandom);
    check("latched_window_ncbps", 32'(ncbps), 32'(nb));

    for (int c = 0; c < 20000; c++) begin
      if (bus.intlvr_in_valid) begin
        if (ilv_cnt == 0 && n_bursts > 0 && idle_run < min_gap) min_gap = idle_run;
        out_q.push_back(bus.intlvr_in_bit);
        ilv_cnt++;
        idle_run = 0;
        last_vc  = c;
      end else begin
        idle_run++;
      end
      if (frame_done) begin
        done_c = c;
        break;
      end
      if (c == abort_at) begin
        reset                = 1'b1;
        bus.in_valid         = 1'b0;
        bus.intlvr_out_valid = 1'b0;
        @(negedge clk);
        check("abort_no_done_before", 32'(done_c), 32'(-1));
        check_reset_outputs("abort");
        return;
      end
      // Interleaver: consume one symbol, then pulse output-valid after a delay.
      case (ilv_phase)
        0: if (ilv_en && ilv_cnt == nb) begin
          n_bursts++;
          ilv_cnt   = 0;
          ilv_timer = $urandom_range(2, 6);
          ilv_phase = 1;
        end
        1: begin
          ilv_timer--;
          if (ilv_timer == 0) begin
            bus.intlvr_out_valid = 1'b1;
            ilv_timer = $urandom_range(1, 3);
            ilv_phase = 2;
          end
        end
        default: begin
          ilv_timer--;
          if (ilv_timer == 0) begin
            bus.intlvr_out_valid = 1'b0;
            ilv_phase = 0;
          end
        end
      endcase
      vld = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      bus.in_valid = vld && (idx < len);
      bus.in_bit   = (idx < len) ? data[idx] : 1'($urandom);
      if (bus.in_valid && bus.in_ready) idx++;
      frame_start = (c == inject_at);
      if (c == inject_at) begin
        tx_mod        = 2'((mod + 1) % 4);
        frame_bit_len = 16'd5;
      end
      @(negedge clk);
    end

    bus.in_valid         = 1'b0;
    bus.intlvr_out_valid = 1'b0;
    frame_start          = 1'b0;
    check("frame_done_seen", 32'(done_c >= 0), 32'(1));
    check("busy_in_done", 32'(busy), 32'(1));
    check("err_at_done", 32'(err), 32'(err_exp));
    if (ilv_en) begin
      check("out_bits", 32'(out_q.size()), 32'(nsym * nb));
      for (int i = 0; i < out_q.size() && i < nsym * nb; i++) begin
        exp_bit = (i < len) ? data[i] : 1'b0;
        if (first_bad < 0 && out_q[i] !== exp_bit) first_bad = i;
      end
      check("bit_order_first_bad", 32'(first_bad), 32'(-1));
      check("bursts", 32'(n_bursts), 32'(nsym));
      check("sym_cnt", 32'(sym_cnt), 32'(nsym));
      if (nsym > 1) check("gap_ge_min", 32'(min_gap >= GAP_CYCLES), 32'(1));
    end else begin
      check("timeout_latency", 32'(done_c - last_vc), 32'(GAP_CYCLES + WAIT_TIMEOUT));
      check("timeout_bits", 32'(out_q.size()), 32'(nb));
      check("timeout_sym_cnt", 32'(sym_cnt), 32'(0));
    end
    @(negedge clk);
    check("done_one_cycle", 32'(frame_done), 32'(0));
    check("busy_after", 32'(busy), 32'(0));
    check("err_after", 32'(err), 32'(err_exp));
    check_window("held", mod);
  endtask

  initial begin
    int m, l;
    reset                = 1'b1;
    frame_start          = 1'b0;
    tx_mod               = 2'd0;
    frame_bit_len        = 16'd0;
    bus.in_valid         = 1'b0;
    bus.in_bit           = 1'b0;
    bus.intlvr_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    run_frame(0, 96, 0, 1'b1, -1, -1);    // BPSK, two full bursts
    run_frame(3, 300, 0, 1'b1, -1, -1);   // 64QAM, 288 + 12 data + 276 pad
    run_frame(1, 192, 1, 1'b1, 40, -1);   // QPSK toggling valid, stray frame_start
    run_frame(2, 0, 0, 1'b1, -1, -1);     // empty frame
    for (int k = 0; k < 3; k++) begin
      m = $urandom_range(0, 3);
      l = $urandom_range(1, 700);
      run_frame(m, l, 2, 1'b1, -1, -1);
    end

    err_exp = 1'b1;
    run_frame(0, 48, 0, 1'b0, -1, -1);    // silent interleaver -> timeout
    run_frame(1, 10, 2, 1'b1, -1, -1);    // err stays sticky

    run_frame(2, 400, 0, 1'b1, -1, 60);   // reset mid 16QAM LOAD
    err_exp = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check("post_abort_done", 32'(frame_done), 32'(0));
    check("post_abort_busy", 32'(busy), 32'(0));
    run_frame(2, 250, 2, 1'b1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
